reg_file_mp: RTL and testbench

- Parametrised multi-port register file for the pipelined CPU. Successor to the single-write, dual-read register file.
- Adds a configurable number of read ports, two write ports (ALU writeback and load/memory writeback) and a per-register pending scoreboard for hazard detection.
- Same-cycle write-to-read forwarding is optional.
- Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

---
 rtl/reg_file_mp.sv | 121 ++++++++++++
 tb/tb_reg_file_mp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports and a pending scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_FILE_WR_BYPASS_EN.
module reg_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  pend_r;
  logic [DEPTH-1:0]  pend_nxt_s;
  logic [DEPTH-1:0]  clr_s;
  logic [DEPTH-1:0]  set_s;
  logic [ADDR_W:0]   pend_cnt_r;
  logic [ADDR_W-1:0] ra_s [NUM_RD];

  function automatic logic [DEPTH-1:0] onehot(input logic [ADDR_W-1:0] a);
    onehot = {{(DEPTH-1){1'b0}}, 1'b1} << a;
  endfunction

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] sum;
    sum = {(ADDR_W+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      sum = sum + {{ADDR_W{1'b0}}, v[i]};
    end
    popcount = sum;
  endfunction

  for (genvar k = 0; k < NUM_RD; k++) begin : g_ra
    assign ra_s[k] = rd_addr[k*ADDR_W +: ADDR_W];
  end

  assign clr_s = (wa_en ? onehot(wa_addr) : {DEPTH{1'b0}}) |
                 (wb_en ? onehot(wb_addr) : {DEPTH{1'b0}});
  assign set_s = sb_set ? onehot(sb_addr) : {DEPTH{1'b0}};

  // Next pending vector: set beats write-clear, flush beats both, register 0 never pends.
  always_comb begin
    pend_nxt_s = {DEPTH{1'b0}};
    if (flush) begin
      pend_nxt_s = {DEPTH{1'b0}};
    end else begin
      pend_nxt_s = ((pend_r & ~clr_s) | set_s) & {{(DEPTH-1){1'b1}}, 1'b0};
    end
  end

  // Register storage: port B is written last so it wins on an address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (wa_en && (wa_addr != {ADDR_W{1'b0}})) begin
        mem_r[wa_addr] <= wa_data;
      end
      if (wb_en && (wb_addr != {ADDR_W{1'b0}})) begin
        mem_r[wb_addr] <= wb_data;
      end
    end
  end

  // Scoreboard state and its registered population count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r     <= {DEPTH{1'b0}};
      pend_cnt_r <= {(ADDR_W+1){1'b0}};
    end else begin
      pend_r     <= pend_nxt_s;
      pend_cnt_r <= popcount(pend_nxt_s);
    end
  end

  assign pend_cnt = pend_cnt_r;

  // Combinational read ports, forced to zero while reset is asserted.
  always_comb begin
    rd_data = {(NUM_RD*DATA_W){1'b0}};
    rd_busy = {NUM_RD{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      if (rst) begin
        rd_data[k*DATA_W +: DATA_W] = mem_r[ra_s[k]];
        rd_busy[k]                  = pend_r[ra_s[k]];
`ifdef REG_FILE_WR_BYPASS_EN
        if ((ra_s[k] != {ADDR_W{1'b0}}) && wb_en && (wb_addr == ra_s[k])) begin
          rd_data[k*DATA_W +: DATA_W] = wb_data;
          rd_busy[k]                  = sb_set && (sb_addr == ra_s[k]);
        end else if ((ra_s[k] != {ADDR_W{1'b0}}) && wa_en && (wa_addr == ra_s[k])) begin
          rd_data[k*DATA_W +: DATA_W] = wa_data;
          rd_busy[k]                  = sb_set && (sb_addr == ra_s[k]);
        end else begin
          rd_data[k*DATA_W +: DATA_W] = mem_r[ra_s[k]];
        end
`endif
      end else begin
        rd_data[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rd_busy[k]                  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: array-based reference model compared every cycle plus directed literal checks.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 2**AW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR*AW-1:0]  rd_addr = '0;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wa_en = 1'b0;
  logic [AW-1:0]     wa_addr = '0;
  logic [DW-1:0]     wa_data = '0;
  logic              wb_en = 1'b0;
  logic [AW-1:0]     wb_addr = '0;
  logic [DW-1:0]     wb_data = '0;
  logic              sb_set = 1'b0;
  logic [AW-1:0]     sb_addr = '0;
  logic              flush = 1'b0;
  logic [AW:0]       pend_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: register contents and pending flags as plain arrays.
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_pend [DEPTH];

  function automatic logic next_pend(int i);
    logic p;
    p = m_pend[i];
    if ((wa_en && wa_addr == AW'(i)) || (wb_en && wb_addr == AW'(i))) p = 1'b0;
    if (sb_set && sb_addr == AW'(i)) p = 1'b1;
    if (flush || i == 0) p = 1'b0;
    return p;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  <= '0;
        m_pend[i] <= 1'b0;
      end
    end else begin
      if (wa_en && wa_addr != 0) m_mem[wa_addr] <= wa_data;
      if (wb_en && wb_addr != 0) m_mem[wb_addr] <= wb_data;
      for (int i = 0; i < DEPTH; i++) m_pend[i] <= next_pend(i);
    end
  end

  function automatic int exp_cnt();
    int c;
    c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic logic [DW-1:0] exp_data(int k);
    logic [AW-1:0] a;
    a = rd_addr[k*AW +: AW];
    if (!rst) return '0;
`ifdef REG_FILE_WR_BYPASS_EN
    if (a != 0 && wb_en && wb_addr == a) return wb_data;
    if (a != 0 && wa_en && wa_addr == a) return wa_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(int k);
    logic [AW-1:0] a;
    a = rd_addr[k*AW +: AW];
    if (!rst) return 1'b0;
`ifdef REG_FILE_WR_BYPASS_EN
    if (a != 0 && ((wa_en && wa_addr == a) || (wb_en && wb_addr == a)) && !(sb_set && sb_addr == a))
      return 1'b0;
`endif
    return m_pend[a];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, inputs stable mid low phase.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("model_data%0d", k), 64'(rd_data[k*DW +: DW]), 64'(exp_data(k)));
        chk($sformatf("model_busy%0d", k), 64'(rd_busy[k]), 64'(exp_busy(k)));
      end
      chk("model_cnt", 64'(pend_cnt), 64'(exp_cnt()));
    end
  end

  task automatic cyc(input logic a_en, input logic [AW-1:0] a_ad, input logic [DW-1:0] a_d,
                     input logic b_en, input logic [AW-1:0] b_ad, input logic [DW-1:0] b_d,
                     input logic s, input logic [AW-1:0] s_ad, input logic f,
                     input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    @(negedge clk);
    wa_en = a_en; wa_addr = a_ad; wa_data = a_d;
    wb_en = b_en; wb_addr = b_ad; wb_data = b_d;
    sb_set = s; sb_addr = s_ad; flush = f;
    rd_addr = {r1, r0};
    #3;
  endtask

  task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, r0, r1);
  endtask

  initial begin
    idle(5'd5, 5'd7);
    idle(5'd5, 5'd7);
    chk("reset_cnt", 64'(pend_cnt), 64'd0);
    chk("reset_data", 64'(rd_data), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Write reg 5, mark it pending, then assert reset mid-cycle.
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5, 5'd0);
    chk("wr5_data", 64'(rd_data[DW-1:0]), 64'hDEADBEEF);
    idle(5'd5, 5'd5);
    chk("pend5_busy", 64'(rd_busy), 64'h3);
    chk("pend5_cnt", 64'(pend_cnt), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_data", 64'(rd_data), 64'd0);
    chk("midrst_busy", 64'(rd_busy), 64'd0);
    chk("midrst_cnt", 64'(pend_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(5'd5, 5'd0);
    chk("post_rst_data", 64'(rd_data[DW-1:0]), 64'd0);

    // Same-address dual write: port B wins.
    cyc(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    idle(5'd3, 5'd0);
    chk("dual_wr_b_wins", 64'(rd_data[DW-1:0]), 64'h22);

    // Register 0 ignores writes and scoreboard sets.
    cyc(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    chk("r0_data", 64'(rd_data), 64'd0);
    chk("r0_busy", 64'(rd_busy), 64'd0);
    chk("r0_cnt", 64'(pend_cnt), 64'd0);

    // Scoreboard on reg 7: set, set-with-write, then clear by port B.
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd7);
    idle(5'd7, 5'd7);
    chk("sb7_busy", 64'(rd_busy[0]), 64'd1);
    chk("sb7_cnt", 64'(pend_cnt), 64'd1);
    cyc(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd7);
    idle(5'd7, 5'd7);
    chk("sb7_set_wins", 64'(rd_busy[0]), 64'd1);
    chk("sb7_data", 64'(rd_data[DW-1:0]), 64'h77);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h78, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
    idle(5'd7, 5'd7);
    chk("sb7_clr_busy", 64'(rd_busy[0]), 64'd0);
    chk("sb7_clr_cnt", 64'(pend_cnt), 64'd0);

    // Pending 1..4, then flush with a concurrent set and write.
    for (int i = 1; i <= 4; i++)
      cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, AW'(i), 1'b0, AW'(i), 5'd9);
    idle(5'd4, 5'd9);
    chk("sb1to4_cnt", 64'(pend_cnt), 64'd4);
    cyc(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd4, 5'd9);
    idle(5'd4, 5'd9);
    chk("flush_cnt", 64'(pend_cnt), 64'd0);
    chk("flush_busy9", 64'(rd_busy[1]), 64'd0);
    chk("flush_wr_data", 64'(rd_data[DW-1:0]), 64'h44);

    // Every register except 0 pending: maximum count.
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, AW'(i), 1'b0, AW'(i), 5'd0);
    idle(5'd31, 5'd0);
    chk("max_cnt", 64'(pend_cnt), 64'd31);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd31, 5'd0);
    idle(5'd31, 5'd0);
    chk("max_flush_cnt", 64'(pend_cnt), 64'd0);

    // Write forwarding on read port 1.
    cyc(1'b1, 5'd12, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd12);
    idle(5'd0, 5'd12);
    cyc(1'b1, 5'd12, 32'hABCD, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd12);
`ifdef REG_FILE_WR_BYPASS_EN
    chk("bypass_same_cycle", 64'(rd_data[DW +: DW]), 64'hABCD);
`else
    chk("no_bypass_old", 64'(rd_data[DW +: DW]), 64'h1234);
`endif
    idle(5'd0, 5'd12);
    chk("wr12_next_cycle", 64'(rd_data[DW +: DW]), 64'hABCD);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hBEEF, 1'b1, 5'd12, 1'b0, 5'd12, 5'd12);
    idle(5'd12, 5'd12);
    chk("wr12_busy_after", 64'(rd_busy), 64'h3);
    idle(5'd0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
